// File: rtl/clk_div_ctrl.sv
// ---------------------------------------------------------------------------
// clk_div_ctrl
//
// Run-time controller for the board clock divider. It sequences start/stop,
// accepts new divisors over a valid/ready handshake, and changes the divisor
// only at period boundaries so that the divided outputs never glitch. It
// produces a one-cycle tick at the end of every period and a divided level
// clock (clk_out) for slow-rate consumers such as timers, debouncers and
// displays.
//
// Optional feature macro: CLK_DIV_CTRL_ONESHOT_EN
//   When defined, the input 'oneshot' exists. It is sampled together with
//   start in IDLE. oneshot=1 runs exactly one period and then returns to
//   IDLE, as if stop had already been taken. When the macro is undefined the
//   port is absent and every start runs until stop.
//
// Parameters
//   WIDTH        width of the divisor and of the period counter
//   DEFAULT_DIV  active divisor after reset
//   MIN_DIV      smallest legal divisor; smaller offers are rejected
//
// Ports
//   clk_in      in   1      board clock
//   rst_n       in   1      asynchronous active-low reset
//   start       in   1      level-sampled request to run
//   stop        in   1      level-sampled request to stop after this period
//   oneshot     in   1      (only with CLK_DIV_CTRL_ONESHOT_EN) run one period
//   cfg_valid   in   1      new divisor offered
//   cfg_div     in   WIDTH  offered divisor
//   cfg_ready   out  1      controller can accept a divisor (no pending one)
//   cfg_err     out  1      one-cycle pulse: accepted divisor was illegal
//   running     out  1      high while in RUN or DRAIN
//   tick        out  1      one-cycle pulse at the end of each period
//   clk_out     out  1      divided clock, high for first floor(div/2) counts
//   period_cnt  out  16     completed periods since reset, wraps to 0
// ---------------------------------------------------------------------------
module clk_div_ctrl #(
   parameter int          WIDTH       = 28,
   parameter int unsigned DEFAULT_DIV = 100000000,
   parameter int unsigned MIN_DIV     = 2
) (
   input  logic             clk_in,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
`ifdef CLK_DIV_CTRL_ONESHOT_EN
   input  logic             oneshot,
`endif
   input  logic             cfg_valid,
   input  logic [WIDTH-1:0] cfg_div,
   output logic             cfg_ready,
   output logic             cfg_err,
   output logic             running,
   output logic             tick,
   output logic             clk_out,
   output logic [15:0]      period_cnt
);

   localparam logic [WIDTH-1:0] DEF_DIV_W = WIDTH'(DEFAULT_DIV);
   localparam logic [WIDTH-1:0] MIN_DIV_W = WIDTH'(MIN_DIV);
   localparam logic [WIDTH-1:0] ONE_W     = WIDTH'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   // -----------------------------------------------------------------------
   // State and datapath registers
   // -----------------------------------------------------------------------
   state_t           state_reg, state_next;
   logic [WIDTH-1:0] cnt_reg, cnt_next;
   logic [WIDTH-1:0] active_div_reg, active_div_next;
   logic [WIDTH-1:0] pend_div_reg, pend_div_next;
   logic             pend_valid_reg, pend_valid_next;

   // Registered outputs
   logic             tick_reg, tick_next;
   logic             clk_out_reg, clk_out_next;
   logic             cfg_err_reg, cfg_err_next;
   logic [15:0]      period_cnt_reg, period_cnt_next;

   // Shared decode
   logic             counting;
   logic             wrap;
   logic             cfg_xfer;
   logic             cfg_legal;
   logic             oneshot_req;
   logic [WIDTH-1:0] half_div;

`ifdef CLK_DIV_CTRL_ONESHOT_EN
   assign oneshot_req = oneshot;
`else
   assign oneshot_req = 1'b0;
`endif

   // RUN and DRAIN count identically; only what happens at the wrap differs.
   assign counting  = (state_reg != IDLE);
   // active_div >= MIN_DIV >= 2, so the subtraction cannot underflow.
   assign wrap      = counting && (cnt_reg == (active_div_reg - ONE_W));
   assign half_div  = active_div_reg >> 1;
   assign cfg_xfer  = cfg_valid && !pend_valid_reg;
   assign cfg_legal = (cfg_div >= MIN_DIV_W);

   // -----------------------------------------------------------------------
   // FSM: state register
   // -----------------------------------------------------------------------
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // -----------------------------------------------------------------------
   // FSM: next-state logic
   // -----------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            // start together with stop is treated as "do nothing".
            if (start && !stop) begin
               state_next = oneshot_req ? DRAIN : RUN;
            end
         end
         RUN: begin
            // A stop landing on the final count of a period ends right here;
            // otherwise the current period is allowed to finish in DRAIN.
            if (stop) begin
               state_next = wrap ? IDLE : DRAIN;
            end
         end
         DRAIN: begin
            // A fresh start cancels the pending stop. It also wins over a
            // simultaneous wrap so the divider keeps running without a gap.
            if (start && !stop) begin
               state_next = RUN;
            end else if (wrap) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // -----------------------------------------------------------------------
   // FSM: outputs decoded from the state register
   // -----------------------------------------------------------------------
   always_comb begin
      running   = counting;
      cfg_ready = !pend_valid_reg;
   end

   // -----------------------------------------------------------------------
   // Period counter
   // -----------------------------------------------------------------------
   always_comb begin
      cnt_next = cnt_reg;
      if (!counting || wrap) begin
         cnt_next = '0;
      end else begin
         cnt_next = cnt_reg + ONE_W;
      end
   end

   // -----------------------------------------------------------------------
   // Divisor handshake
   //   Idle: a legal divisor takes effect immediately.
   //   Counting: it is parked in pend_div and swapped in at the next wrap,
   //   so a period is never shortened or stretched mid-way. A transfer can
   //   only happen while nothing is pending, so a divisor accepted on a wrap
   //   cycle cannot collide with the swap and waits for the following wrap.
   // -----------------------------------------------------------------------
   always_comb begin
      active_div_next = active_div_reg;
      pend_div_next   = pend_div_reg;
      pend_valid_next = pend_valid_reg;

      if (wrap && pend_valid_reg) begin
         active_div_next = pend_div_reg;
         pend_valid_next = 1'b0;
      end

      if (cfg_xfer && cfg_legal) begin
         if (!counting) begin
            active_div_next = cfg_div;
         end else begin
            pend_div_next   = cfg_div;
            pend_valid_next = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg        <= '0;
         active_div_reg <= DEF_DIV_W;
         pend_div_reg   <= '0;
         pend_valid_reg <= 1'b0;
      end else begin
         cnt_reg        <= cnt_next;
         active_div_reg <= active_div_next;
         pend_div_reg   <= pend_div_next;
         pend_valid_reg <= pend_valid_next;
      end
   end

   // -----------------------------------------------------------------------
   // Registered outputs (one cycle behind the counter)
   // -----------------------------------------------------------------------
   always_comb begin
      tick_next       = wrap;
      clk_out_next    = counting && (cnt_reg < half_div);
      cfg_err_next    = cfg_xfer && !cfg_legal;
      period_cnt_next = wrap ? (period_cnt_reg + 16'd1) : period_cnt_reg;
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         tick_reg       <= 1'b0;
         clk_out_reg    <= 1'b0;
         cfg_err_reg    <= 1'b0;
         period_cnt_reg <= 16'd0;
      end else begin
         tick_reg       <= tick_next;
         clk_out_reg    <= clk_out_next;
         cfg_err_reg    <= cfg_err_next;
         period_cnt_reg <= period_cnt_next;
      end
   end

   assign tick       = tick_reg;
   assign clk_out    = clk_out_reg;
   assign cfg_err    = cfg_err_reg;
   assign period_cnt = period_cnt_reg;

endmodule
